// File: rtl/common_types_pkg.sv
// Shared types for the divider front end: operation encoding, controller states.
// No logic of its own; helper function is purely combinational.
// No flow control here; consumers handle backpressure.
package common_types_pkg;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 5;

   // bit1 = remainder, bit0 = unsigned
   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } div_ctrl_state_t;

   // The divider negates r whenever the operand signs differ; RISC-V wants the
   // dividend's sign, so a negative divisor means the divider's choice was wrong.
   function automatic logic [DATA_W-1:0] fix_rem(input logic [DATA_W-1:0] r,
                                                 input logic is_signed,
                                                 input logic b_msb,
                                                 input logic dz,
                                                 input logic ovf);
      return (is_signed && b_msb && !dz && !ovf) ? (~r + 32'd1) : r;
   endfunction

endpackage

// File: rtl/div_rr_arbiter.sv
// Two-way round-robin arbiter: single requester wins; on contention the one not granted last wins.
// Purely combinational, zero latency.
// No backpressure of its own; the caller gates the grant with its own readiness.
module div_rr_arbiter (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant,
   output logic       grant_idx
);

   // pick the index, then expand it to a one-hot grant only when someone asks
   always_comb begin
      grant_idx = 1'b0;
      grant     = 2'b00;
      case (req)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last;
         default: grant_idx = 1'b0;
      endcase
      if (req != 2'b00)
         grant = grant_idx ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/div_ctrl.sv
// Two-requester front end for the shared 32-bit divider (DIV/DIVU/REM/REMU); optional DIV_CTRL_RESULT_CACHE_EN.
// Latency handshake->rsp_valid: 36 cycles normal, 3 on div-by-zero/overflow, 1 on result-cache hit.
// One transaction in flight: req_ready low outside IDLE; response held stable until rsp_ready.
// The divider's own reset (nrst = ~rst, synchronised) is wired at integration so both restart idle together.
module div_ctrl
   import common_types_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0][1:0]        req_op,
   input  logic [1:0][DATA_W-1:0] req_a,
   input  logic [1:0][DATA_W-1:0] req_b,
   input  logic [1:0][TAG_W-1:0]  req_tag,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_id,
   output logic [TAG_W-1:0]       rsp_tag,
   output logic [DATA_W-1:0]      rsp_data,
   output logic                   rsp_dz,
   output logic                   rsp_ovf,
   output logic                   div_en,
   output logic                   div_is_signed,
   output logic [DATA_W-1:0]      div_a,
   output logic [DATA_W-1:0]      div_b,
   input  logic                   div_ready,
   input  logic [DATA_W-1:0]      div_q,
   input  logic [DATA_W-1:0]      div_r,
   input  logic                   div_by_zero,
   input  logic                   div_overflow
);

   div_ctrl_state_t state;
   div_op_t         op_q;
   logic            rr_last;
   logic [1:0]      grant;
   logic            grant_idx;
   logic            req_hs;
   logic            cache_hit;
   logic [DATA_W-1:0] cache_data;
   logic            cache_dz;
   logic            cache_ovf;
   logic [DATA_W-1:0] rem_fixed;

   div_rr_arbiter u_arb (
      .req       (req_valid),
      .last      (rr_last),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // rst gate keeps req_ready at 0 while reset is held even though state reads IDLE
   assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
   assign req_hs    = |(req_valid & req_ready);
   assign rem_fixed = fix_rem(div_r, div_is_signed, div_b[DATA_W-1], div_by_zero, div_overflow);

`ifdef DIV_CTRL_RESULT_CACHE_EN
   logic              c_vld;
   logic [DATA_W-1:0] c_a;
   logic [DATA_W-1:0] c_b;
   logic              c_sgn;
   logic [DATA_W-1:0] c_q;
   logic [DATA_W-1:0] c_r;
   logic              c_dz;
   logic              c_ovf;

   assign cache_hit  = c_vld && (c_a == req_a[grant_idx]) && (c_b == req_b[grant_idx]) &&
                       (c_sgn == ~req_op[grant_idx][0]);
   assign cache_data = req_op[grant_idx][1] ? c_r : c_q;
   assign cache_dz   = c_dz;
   assign cache_ovf  = c_ovf;

   // refill the last-result entry on every divider completion; only reset invalidates it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_vld <= 1'b0;
         c_a   <= '0;
         c_b   <= '0;
         c_sgn <= 1'b0;
         c_q   <= '0;
         c_r   <= '0;
         c_dz  <= 1'b0;
         c_ovf <= 1'b0;
      end else if (state == WAIT && div_ready) begin
         c_vld <= 1'b1;
         c_a   <= div_a;
         c_b   <= div_b;
         c_sgn <= div_is_signed;
         c_q   <= div_q;
         c_r   <= rem_fixed;
         c_dz  <= div_by_zero;
         c_ovf <= div_overflow;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_data = '0;
   assign cache_dz   = 1'b0;
   assign cache_ovf  = 1'b0;
`endif

   // control FSM: capture on grant, pulse div_en once, wait for the divider, hold the response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         op_q          <= DIV;
         rr_last       <= 1'b1;
         div_en        <= 1'b0;
         div_is_signed <= 1'b0;
         div_a         <= '0;
         div_b         <= '0;
         rsp_valid     <= 1'b0;
         rsp_id        <= 1'b0;
         rsp_tag       <= '0;
         rsp_data      <= '0;
         rsp_dz        <= 1'b0;
         rsp_ovf       <= 1'b0;
      end else begin
         div_en <= 1'b0;
         case (state)
            IDLE: begin
               if (req_hs) begin
                  op_q          <= div_op_t'(req_op[grant_idx]);
                  div_is_signed <= ~req_op[grant_idx][0];
                  div_a         <= req_a[grant_idx];
                  div_b         <= req_b[grant_idx];
                  rsp_tag       <= req_tag[grant_idx];
                  rsp_id        <= grant_idx;
                  rr_last       <= grant_idx;
                  if (cache_hit) begin
                     rsp_data  <= cache_data;
                     rsp_dz    <= cache_dz;
                     rsp_ovf   <= cache_ovf;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     div_en <= 1'b1;
                     state  <= ISSUE;
                  end
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               // operands stay put here: the divider reads them combinationally until ready
               if (div_ready) begin
                  rsp_data  <= op_q[1] ? rem_fixed : div_q;
                  rsp_dz    <= div_by_zero;
                  rsp_ovf   <= div_overflow;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Two-requester front end for the shared 32-bit long-division divider, implementing RISC-V M-extension DIV/DIVU/REM/REMU.
- Arbitrates between requester 0 (integer pipeline execute stage) and requester 1 (auxiliary unit, e.g. debug/coprocessor) with a round-robin arbiter.
- Registers the granted operands, holds them stable for the whole divider operation, and sequences the divider's en/ready handshake.
- Selects the quotient or remainder, fixes remainder sign to RISC-V semantics, and returns the result on a shared response channel with backpressure.

Parameters:
- none (fixed 32-bit datapath, 2 requesters)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  request valid, one bit per requester
- req_ready  out  2  request accepted; one-hot or zero
- req_op  in  2x2  per-requester div_op_t
- req_a  in  2x32  per-requester dividend
- req_b  in  2x32  per-requester divisor
- req_tag  in  2x5  per-requester destination tag, echoed in the response
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  index of the requester being answered
- rsp_tag  out  5  echoed tag
- rsp_data  out  32  selected result
- rsp_dz  out  1  divide-by-zero flag
- rsp_ovf  out  1  signed-overflow flag
- div_en  out  1  divider start pulse
- div_is_signed  out  1  signedness to divider
- div_a  out  32  registered dividend to divider
- div_b  out  32  registered divisor to divider
- div_ready  in  1  divider result valid
- div_q  in  32  divider quotient
- div_r  in  32  divider remainder
- div_by_zero  in  1  divider flag
- div_overflow  in  1  divider flag

Behaviour:
- Reset: async assert forces state=IDLE, rr_last=1 (requester 0 wins first), and all operand/result registers to 0. Every output is 0 while rst is high.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, grant goes to the requester not granted last.
  - req_ready is asserted combinationally for the granted index only.
  - On handshake: capture op, a, b, tag and id; update rr_last; go to ISSUE.
- ISSUE (1 cycle): div_en=1 for exactly this cycle; go to WAIT.
- WAIT: hold div_a, div_b and div_is_signed stable. The divider's q/r sign correction reads them combinationally, so they must not change until ready. On div_ready: capture the result and flags, go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* fields remain stable until rsp_ready.
  - On rsp_valid & rsp_ready, return to IDLE. No new request is accepted in the same cycle.
  - req_ready=0 in ISSUE, WAIT and RESP.
- Result selection:
  - div_is_signed = ~op[0].
  - op[1]=0: rsp_data=div_q.
  - op[1]=1: rsp_data=div_r.
  - Remainder sign fix: the divider negates r when a[31]^b[31], but RISC-V needs the sign of the dividend. For a signed REM with b[31]=1 and no dz/ovf, output ~div_r+1; otherwise output div_r unchanged.
  - rsp_dz = div_by_zero, rsp_ovf = div_overflow.
  - Resulting values: dz gives q=0xFFFFFFFF, r=a; ovf gives q=0x80000000, r=0.
- Latency, counted from the handshake cycle T:
  - Normal operation: rsp_valid at T+36 (ISSUE T+1, PRECHECK T+2, 32 DIVIDE cycles, DONE T+35).
  - dz/ovf early exit: rsp_valid at T+3.
- div_ready outside WAIT is ignored.
- Async reset mid-operation: the requester's transaction is dropped with no response. rst must also drive the divider's reset (nrst = ~rst, synchronised) so both blocks restart idle together.

Optional Feature:
- Macro: DIV_CTRL_RESULT_CACHE_EN.
- With the macro defined:
  - Keep a last-result entry: valid bit, a, b, signedness, corrected quotient, corrected remainder, dz, ovf. It is filled on every divider completion.
  - An accepted request whose a, b and signedness match a valid entry goes IDLE→RESP directly (rsp_valid at T+1, no div_en). This fuses DIV+REM pairs.
  - The valid bit is cleared by reset only.
- Without the macro: every request goes through the divider.

Decomposition:
- common_types_pkg entries:
  - div_op_t: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11 (bit1=remainder, bit0=unsigned).
  - div_ctrl_state_t: IDLE, ISSUE, WAIT, RESP.
- Sub-module div_rr_arbiter: 2-way round-robin, inputs req[1:0] and last, outputs grant one-hot and grant index.

Test Plan:
- req0 DIVU a=100 b=7 → rsp_data=14, rsp_id=0, rsp_valid at T+36; REMU same operands → 2.
- REM a=0xFFFFFFF9 b=2 → 0xFFFFFFFF; REM a=7 b=0xFFFFFFFE → 1; DIV a=7 b=0xFFFFFFFE → 0xFFFFFFFD.
- DIV 5/0 → 0xFFFFFFFF with rsp_dz=1 at T+3; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 with rsp_ovf=1; REM of the same → 0.
- Both req_valid held high for 4 transactions → grants 0,1,0,1. rsp_ready low for 10 cycles → rsp_* stable, req_ready=0 throughout.
- rst pulsed during WAIT → all outputs 0 immediately, no response. The next req1 DIVU 9/3 → 3.
- DIV 1000/3 then REM 1000/3 (same requester):
  - With macro: second rsp_data=1 at T+1.
  - Without macro: T+36.
